// File: rtl/pin_sender.sv
// pin_sender: replays a 4-digit BCD PIN onto a lock's one-hot tenkey input.
// Each digit is held for PRESS_CYCLES, then released for GAP_CYCLES, most
// significant digit first. A start with any nibble above 9 is rejected with
// a one-cycle err pulse and nothing is driven.
// Optional feature macro: CLOSE_FIRST_EN -- when defined, every accepted
// sequence begins with a one-cycle close pulse and a GAP_CYCLES quiet period
// so the lock is re-armed with an empty key history before the first press.
//
//  state    | meaning
//  ---------+------------------------------------------------------------
//  ST_IDLE  | waiting for start; code checked and latched here
//  ST_CLOSE | close pulse high for one cycle (CLOSE_FIRST_EN only)
//  ST_CGAP  | tenkey quiet after the close pulse (CLOSE_FIRST_EN only)
//  ST_PRESS | one-hot key of the current digit held
//  ST_GAP   | tenkey released between presses
//  ST_FIN   | done pulse, busy dropped, start ignored
module pin_sender #(
   parameter int PRESS_CYCLES = 4,
   parameter int GAP_CYCLES   = 4,
   parameter int CNT_W        = 8
) (
   input  logic        ck,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] code,
   output logic [9:0]  tenkey,
   output logic        close,
   output logic        busy,
   output logic        done,
   output logic        err
);

   // Timers count down from len-1 and move on at zero, so each phase spans
   // exactly len cycles including the entry cycle.
   localparam logic [CNT_W-1:0] PRESS_LOAD = CNT_W'(PRESS_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);

`ifdef CLOSE_FIRST_EN
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PRESS = 3'd1,
      ST_GAP   = 3'd2,
      ST_FIN   = 3'd3,
      ST_CLOSE = 3'd4,
      ST_CGAP  = 3'd5
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRESS = 2'd1,
      ST_GAP   = 2'd2,
      ST_FIN   = 2'd3
   } state_t;
`endif

   state_t           state;
   logic [15:0]      code_l;
   logic [1:0]       idx;
   logic [CNT_W-1:0] timer;

   logic             code_ok;
   logic             timer_zero;
   logic [1:0]       idx_dn;
   logic [3:0]       next_digit;

   // Decode a BCD digit to its key line; anything above 9 drives no key,
   // which keeps tenkey one-hot-or-zero whatever reaches this point.
   function automatic logic [9:0] key_onehot(input logic [3:0] d);
      logic [9:0] k;
      k = 10'd0;
      if (d <= 4'd9) begin
         k[d] = 1'b1;
      end
      return k;
   endfunction

   // Validity of the incoming code, timer terminal count and the digit that
   // follows the current one in the latched code.
   always_comb begin
      code_ok    = (code[15:12] <= 4'd9) && (code[11:8] <= 4'd9) &&
                   (code[7:4]   <= 4'd9) && (code[3:0]  <= 4'd9);
      timer_zero = (timer == '0);
      idx_dn     = idx - 2'd1;
      next_digit = code_l[{idx_dn, 2'b00} +: 4];
   end

   // Sequencer: state, timer, digit index and all registered outputs.
   always_ff @(posedge ck or posedge reset) begin
      if (reset) begin
         state  <= ST_IDLE;
         code_l <= '0;
         idx    <= 2'd3;
         timer  <= '0;
         tenkey <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         err    <= 1'b0;
`ifdef CLOSE_FIRST_EN
         close  <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
`ifdef CLOSE_FIRST_EN
         close <= 1'b0;
`endif
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (code_ok) begin
                     code_l <= code;
                     idx    <= 2'd3;
                     busy   <= 1'b1;
`ifdef CLOSE_FIRST_EN
                     state  <= ST_CLOSE;
                     close  <= 1'b1;
                     timer  <= '0;
`else
                     state  <= ST_PRESS;
                     tenkey <= key_onehot(code[15:12]);
                     timer  <= PRESS_LOAD;
`endif
                  end else begin
                     err <= 1'b1;
                  end
               end
            end

`ifdef CLOSE_FIRST_EN
            ST_CLOSE: begin
               state <= ST_CGAP;
               timer <= GAP_LOAD;
            end

            ST_CGAP: begin
               if (timer_zero) begin
                  state  <= ST_PRESS;
                  tenkey <= key_onehot(code_l[15:12]);
                  timer  <= PRESS_LOAD;
               end else begin
                  timer <= timer - 1'b1;
               end
            end
`endif

            ST_PRESS: begin
               if (timer_zero) begin
                  state  <= ST_GAP;
                  tenkey <= '0;
                  timer  <= GAP_LOAD;
               end else begin
                  timer <= timer - 1'b1;
               end
            end

            // Every digit, repeated or not, gets a full release gap so the
            // lock sees a fresh rising edge per press.
            ST_GAP: begin
               if (timer_zero) begin
                  if (idx != 2'd0) begin
                     idx    <= idx_dn;
                     state  <= ST_PRESS;
                     tenkey <= key_onehot(next_digit);
                     timer  <= PRESS_LOAD;
                  end else begin
                     state <= ST_FIN;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                  end
               end else begin
                  timer <= timer - 1'b1;
               end
            end

            ST_FIN: begin
               state <= ST_IDLE;
               idx   <= 2'd3;
            end

            default: begin
               state  <= ST_IDLE;
               tenkey <= '0;
               busy   <= 1'b0;
            end
         endcase
      end
   end

`ifndef CLOSE_FIRST_EN
   assign close = 1'b0;
`endif

endmodule

// File: tb/tb_pin_sender.sv
// Testbench for pin_sender: stimulus pushes expected output-change events
// (signal, value, edge index) into a time-ordered queue; a monitor pops and
// compares on every change it sees on the DUT outputs.
module tb_pin_sender;

   localparam int P = 4;
   localparam int G = 4;

   logic        ck = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [15:0] code = 16'h0000;
   logic [9:0]  tenkey;
   logic        close;
   logic        busy;
   logic        done;
   logic        err;

   pin_sender #(.PRESS_CYCLES(P), .GAP_CYCLES(G), .CNT_W(8)) dut (
      .ck     (ck),
      .reset  (reset),
      .start  (start),
      .code   (code),
      .tenkey (tenkey),
      .close  (close),
      .busy   (busy),
      .done   (done),
      .err    (err)
   );

   // Clock.
   always #5 ck = ~ck;

   // Edge index; outputs sampled at a falling edge reflect edge E.
   int E = 0;
   always @(posedge ck) E = E + 1;

   typedef struct {
      int sig;
      int val;
      int cyc;
   } ev_t;

   // sig ids: 0 busy, 1 close, 2 tenkey, 3 done, 4 err
   ev_t q[$];
   int  checks = 0;
   int  errors = 0;
   int  free_edge = 0;
   bit  mon_en = 1'b0;

   function automatic void push_ev(input int s, input int v, input int c);
      ev_t e;
      int  i;
      e.sig = s;
      e.val = v;
      e.cyc = c;
      i = 0;
      while (i < q.size() && (q[i].cyc < c || (q[i].cyc == c && q[i].sig <= s)))
         i++;
      q.insert(i, e);
   endfunction

   // Reference model: what a start sampled at edge n should produce.
   function automatic void model_start(input logic [15:0] c, input int n);
      int  dig [4];
      bit  ok;
      int  k0;
      int  fin;
      if (n < free_edge) return;
      ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
         dig[i] = (int'(c) >> (4 * (3 - i))) & 15;
         if (dig[i] > 9) ok = 1'b0;
      end
      if (!ok) begin
         push_ev(4, 1, n);
         push_ev(4, 0, n + 1);
         return;
      end
      push_ev(0, 1, n);
`ifdef CLOSE_FIRST_EN
      push_ev(1, 1, n);
      push_ev(1, 0, n + 1);
      k0 = n + 1 + G;
`else
      k0 = n;
`endif
      for (int i = 0; i < 4; i++) begin
         push_ev(2, 1 << dig[i], k0 + i * (P + G));
         push_ev(2, 0, k0 + i * (P + G) + P);
      end
      fin = k0 + 4 * (P + G);
      push_ev(0, 0, fin);
      push_ev(3, 1, fin);
      push_ev(3, 0, fin + 1);
      free_edge = fin + 2;
   endfunction

   function automatic void see_change(input int s, input int cur, input int prev);
      ev_t e;
      if (cur == prev) return;
      checks++;
      if (q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event sig=%0d got val=%0h at edge %0d, expected no change",
                  s, cur, E);
      end else begin
         e = q.pop_front();
         if (e.sig != s || e.val != cur || e.cyc != E) begin
            errors++;
            $display("FAIL event got sig=%0d val=%0h edge=%0d, expected sig=%0d val=%0h edge=%0d",
                     s, cur, E, e.sig, e.val, e.cyc);
         end
      end
   endfunction

   logic [9:0] p_key;
   logic       p_busy, p_close, p_done, p_err;

   // Monitor: compare every output change against the scoreboard.
   always @(negedge ck) begin
      if (mon_en) begin
         see_change(0, int'(busy), int'(p_busy));
         see_change(1, int'(close), int'(p_close));
         see_change(2, int'(tenkey), int'(p_key));
         see_change(3, int'(done), int'(p_done));
         see_change(4, int'(err), int'(p_err));
      end
      p_busy  = busy;
      p_close = close;
      p_key   = tenkey;
      p_done  = done;
      p_err   = err;
   end

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, got, exp);
      end
   endtask

   // Call just after a falling edge; start is sampled at the next rising edge.
   task automatic send(input logic [15:0] c, output int n);
      start = 1'b1;
      code  = c;
      n     = E + 1;
      model_start(c, n);
      @(negedge ck);
      start = 1'b0;
   endtask

   task automatic wait_until(input int m);
      while (E < m - 1) @(negedge ck);
   endtask

   task automatic wait_free();
      while (E + 1 < free_edge) @(negedge ck);
   endtask

   initial begin
      int n, n0;
      int t;
      int sel;
      logic [15:0] c;

      reset = 1'b1;
      repeat (3) @(negedge ck);
      reset = 1'b0;
      @(negedge ck);
      @(negedge ck);
      mon_en = 1'b1;

      chk("reset_tenkey", int'(tenkey), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_err", int'(err), 0);
      chk("reset_close", int'(close), 0);

      send(16'h5963, n);
      wait_free();

      send(16'h1A23, n);
      repeat (4) @(negedge ck);
      chk("bad_code_busy", int'(busy), 0);

      send(16'h0000, n);
      wait_free();

      send(16'h5963, n0);
      wait_until(n0 + 5);
      send(16'h1111, n);
      wait_until(n0 + 1 + 4 * (P + G));
      send(16'h2222, n);
      wait_until(n0 + 2 + 4 * (P + G));
`ifndef CLOSE_FIRST_EN
      send(16'h7080, n);
`else
      wait_free();
      send(16'h7080, n);
`endif
      wait_free();

      send(16'h8642, n);
`ifdef CLOSE_FIRST_EN
      wait_until(n + 1 + 1 + G + P + G);
`else
      wait_until(n + 1 + P + G);
`endif
      chk("pre_reset_key", int'(tenkey), 10'h040);
      mon_en = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      chk("async_reset_tenkey", int'(tenkey), 0);
      chk("async_reset_busy", int'(busy), 0);
      q.delete();
      free_edge = 0;
      @(negedge ck);
      reset = 1'b0;
      @(negedge ck);
      @(negedge ck);
      mon_en = 1'b1;
      send(16'h1234, n);
      wait_free();

      for (int r = 0; r < 25; r++) begin
         repeat ($urandom_range(0, 40)) @(negedge ck);
         c = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
              4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
         if ($urandom_range(0, 3) == 0) begin
            sel = int'($urandom_range(0, 3));
            c[4 * sel +: 4] = 4'($urandom_range(10, 15));
         end
         send(c, n);
      end
      wait_free();

      t = 0;
      while (q.size() != 0 && t < 200) begin
         @(negedge ck);
         t++;
      end
      chk("scoreboard_drained", q.size(), 0);
      repeat (5) @(negedge ck);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
